// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Shares the single register-file write port between the ALU and the load
//   unit. A transfer happens when a requester's valid and ready are both high.
//   Ties are broken round-robin. The accepted write shows up on the register
//   file port one cycle later. Writes to x0 are accepted but never enabled.
//   A saturating counter records the cycles in which a valid request was
//   denied; flush cycles are not counted.
//
// Ports
//   clk                  clock, all state updates on posedge
//   rst                  asynchronous active-low reset
//   flush                synchronous flush: blocks both requesters
//   alu_wb_valid/rd/data ALU write-back request
//   alu_wb_ready         ALU request accepted this cycle (combinational)
//   mem_wb_valid/rd/data load-unit write-back request
//   mem_wb_ready         load-unit request accepted this cycle (combinational)
//   register_write_en    registered register-file write enable
//   rd_address           registered register-file write address
//   register_write_data  registered register-file write data
//   conflict_count       saturating count of cycles with a denied request
module writeback_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        mem_wb_valid,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] mem_wb_data,
    output logic        mem_wb_ready,
    output logic        register_write_en,
    output logic [4:0]  rd_address,
    output logic [31:0] register_write_data,
    output logic [7:0]  conflict_count
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic        alu_ready, mem_ready;
    logic        denied;

    logic        wen_q, wen_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;

    // Grant state register. Reset to the load unit so the ALU wins the
    // first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GRANT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Grant next state: follows every transfer, including ones to x0.
    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_ready) begin
            last_grant_d = GRANT_ALU;
        end else if (mem_ready) begin
            last_grant_d = GRANT_MEM;
        end
    end

    // Grant outputs. Reset is folded in here so neither requester can see
    // ready while the block is held in reset.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst && !flush) begin
            if (alu_wb_valid && (!mem_wb_valid || last_grant_q == GRANT_MEM)) begin
                alu_ready = 1'b1;
            end else if (mem_wb_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    assign alu_wb_ready = alu_ready;
    assign mem_wb_ready = mem_ready;

    // Both requesters denied in one cycle still counts once.
    assign denied = !flush && ((alu_wb_valid && !alu_ready) ||
                               (mem_wb_valid && !mem_ready));

    // Write port: address and data only move on a real write, so a dropped
    // x0 transfer or an idle cycle leaves them holding their last value.
    always_comb begin
        wen_d  = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (alu_ready && alu_wb_rd != 5'd0) begin
            wen_d  = 1'b1;
            rd_d   = alu_wb_rd;
            data_d = alu_wb_data;
        end else if (mem_ready && mem_wb_rd != 5'd0) begin
            wen_d  = 1'b1;
            rd_d   = mem_wb_rd;
            data_d = mem_wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (denied && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign register_write_en   = wen_q;
    assign rd_address          = rd_q;
    assign register_write_data = data_q;
    assign conflict_count      = cnt_q;

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL use the following ports, one per line: name direction width meaning.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline flush; active-high.
REQ-005 alu_wb_valid  input  1  ALU write-back request.
REQ-006 alu_wb_rd  input  5  ALU destination register.
REQ-007 alu_wb_data  input  32  ALU write data.
REQ-008 alu_wb_ready  output  1  ALU request accepted this cycle.
REQ-009 mem_wb_valid  input  1  load-unit write-back request.
REQ-010 mem_wb_rd  input  5  load-unit destination register.
REQ-011 mem_wb_data  input  32  load-unit write data.
REQ-012 mem_wb_ready  output  1  load-unit request accepted this cycle.
REQ-013 register_write_en  output  1  register file write enable, registered.
REQ-014 rd_address  output  5  register file write address, registered.
REQ-015 register_write_data  output  32  register file write data, registered.
REQ-016 conflict_count  output  8  saturating count of cycles in which a valid request was denied.

Function
REQ-017 The block SHALL share the single register-file write port between the ALU and load-unit requesters.
REQ-018 Handshake: a transfer occurs when valid and ready are both 1 in the same cycle; each requester holds valid, rd and data stable until ready.
REQ-019 ready SHALL be combinational from valid, flush and the arbitration state; no transfer is accepted without valid.
REQ-020 Arbitration when only one requester is valid: that requester is granted.
REQ-021 Arbitration when both are valid: round-robin; the requester not granted last is granted.
REQ-022 A 1-bit last_grant register SHALL update to the granted requester on every transfer, including transfers to x0.
REQ-023 At most one ready SHALL be 1 in any cycle.
REQ-024 Latency: a transfer accepted in cycle N SHALL appear on rd_address and register_write_data with register_write_en=1 in cycle N+1, for exactly one cycle.
REQ-025 With no transfer in cycle N, register_write_en SHALL be 0 in cycle N+1; rd_address and register_write_data hold their previous values.
REQ-026 Writes to rd=0 SHALL be accepted (ready=1) but SHALL NOT assert register_write_en.
REQ-027 Back-to-back transfers SHALL be supported every cycle without bubbles.
REQ-028 When flush=1: both ready=0, no transfer, register_write_en=0 next cycle, last_grant unchanged.
REQ-029 conflict_count SHALL increment by 1 in each cycle where a requester has valid=1 but ready=0, excluding flush cycles; it SHALL saturate at 255.
REQ-030 Both requesters denied in the same cycle (flush excluded) SHALL count as one increment.

Reset
REQ-031 On rst=0, asynchronously: register_write_en=0, rd_address=0, register_write_data=0, conflict_count=0, last_grant=load unit (ALU wins the first tie).
REQ-032 While rst=0, both ready outputs SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard the in-flight write; no write-enable pulse after deassertion.

Verification
REQ-034 Tie after reset: both valid, alu rd=5 data=0x11, mem rd=6 data=0x22 held -> cycle 1 alu_wb_ready=1; cycle 2 write rd=5/0x11, mem_wb_ready=1; cycle 3 write rd=6/0x22; conflict_count=1.
REQ-035 Single requester streaming: mem valid 4 consecutive cycles, rd=1..4 -> four consecutive write pulses rd=1..4, 1-cycle latency, conflict_count=0.
REQ-036 x0 drop: alu valid rd=0 data=0xDEADBEEF -> alu_wb_ready=1, register_write_en stays 0, next tie grants mem.
REQ-037 Flush: both valid with flush=1 for 2 cycles -> ready=0 both, no write, conflict_count unchanged; after flush deasserts arbitration resumes from saved last_grant.
REQ-038 Saturation: both valid held 300 cycles -> conflict_count reaches 255 and holds; grants alternate every cycle.
REQ-039 Async reset: rst pulled low between clock edges with register_write_en=1 -> outputs zero immediately, no write after release.
